// File: rtl/gf256_inv_seq_pkg.sv
// Shared AES field constants and inverter state encodings.
// The multiplier and the inverter FSM both import this package.
package gf256_inv_seq_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam logic [2:0] INV_ITER = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gf256_inv_seq_mul.sv
// Combinational GF(2^8) multiplier: shift-and-add with reduction by {1,POLY}.
// The inverter and MixColumns logic both instantiate this module.
module gf256_mul
    import gf256_inv_seq_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY
) (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    logic [7:0] w_acc;
    logic [7:0] w_sh;

    // w_sh tracks a * x^i, reduced on every step so it never exceeds 8 bits
    always_comb begin
        w_acc = 8'h00;
        w_sh  = i_a;
        for (int i = 0; i < 8; i++) begin
            if (i_b[i]) w_acc = w_acc ^ w_sh;
            w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? POLY : 8'h00);
        end
    end

    assign o_p = w_acc;

endmodule

// File: rtl/gf256_inv_seq.sv
// Iterative GF(2^8) inverter: y = x^254 computed by square-and-multiply over 7 cycles.
// Zero maps to zero naturally because every power of zero is zero.
module gf256_inv_seq
    import gf256_inv_seq_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [7:0] i_x,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_y
);

    state_t     r_state;
    logic [7:0] r_s;
    logic [7:0] r_r;
    logic [7:0] r_y;
    logic [2:0] r_cnt;
    logic       r_in_ready;
    logic       r_out_valid;

    logic [7:0] w_t;
    logic [7:0] w_rt;

    gf256_mul #(.POLY(POLY)) u_sq (
        .i_a (r_s),
        .i_b (r_s),
        .o_p (w_t)
    );

    gf256_mul #(.POLY(POLY)) u_mul (
        .i_a (r_r),
        .i_b (w_t),
        .o_p (w_rt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_s         <= 8'h00;
            r_r         <= 8'h00;
            r_y         <= 8'h00;
            r_cnt       <= 3'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_s        <= i_x;
                        r_r        <= 8'h01;
                        r_cnt      <= 3'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_s   <= w_t;
                    r_r   <= w_rt;
                    r_cnt <= r_cnt + 3'd1;
                    // Last step: r already holds x^126, times x^128 gives x^254
                    if (r_cnt == INV_ITER - 3'd1) begin
                        r_y         <= w_rt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_y         = r_y;

endmodule

// File: tb/tb_gf256_inv_seq.sv
// Directed bench for gf256_inv_seq: latency, known inverses, exhaustive sweep,
// backpressure, mid-operation reset and operand changes after acceptance.
module tb_gf256_inv_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;

    int n_tests = 0;
    int n_fail  = 0;

    gf256_inv_seq dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_x         (x),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_y         (y)
    );

    always #5 clk = ~clk;

    // Reference multiply: full carry-less product, then reduce bits 14..8 by 0x11B
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'h11B << (k - 8));
        return p[7:0];
    endfunction

    // Reference inverse by exhaustive search for the unique b with a*b == 1
    function automatic logic [7:0] ref_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        if (a != 8'h00)
            for (int b = 1; b < 256; b++)
                if (ref_mul(a, 8'(b)) == 8'h01) r = 8'(b);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction with out_ready held high; x_late replaces x after acceptance
    task automatic run_one(input string tag, input logic [7:0] x_in,
                           input logic [7:0] x_late, input logic [7:0] exp);
        int n;
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        x        = x_in;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        x        = x_late;
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd7);
        check({tag, " y"}, 32'(y), 32'(exp));
        @(negedge clk);
        check({tag, " popped"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int  cyc;
        int  bad_rdy;
        logic [7:0] got;
        logic stuck_bad;

        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset y", 32'(y), 32'h00);
        rst = 1'b0;

        // Basic vectors
        run_one("x53", 8'h53, 8'h53, 8'hCA);
        run_one("x00", 8'h00, 8'h00, 8'h00);
        run_one("x01", 8'h01, 8'h01, 8'h01);
        run_one("x02", 8'h02, 8'h02, 8'h8D);

        // Exhaustive back-to-back sweep with in_valid held high
        @(negedge clk);
        in_valid = 1'b1;
        for (int v = 0; v < 256; v++) begin
            x       = 8'(v);
            cyc     = 0;
            bad_rdy = 0;
            got     = 8'hXX;
            do begin
                @(negedge clk);
                cyc++;
                if (out_valid) got = y;
                if (in_ready && !out_valid && cyc < 9) bad_rdy++;
                if (in_ready && out_valid) bad_rdy++;
            end while (!in_ready && cyc < 30);
            check($sformatf("sweep y[%0h]", v), 32'(got), 32'(ref_inv(8'(v))));
            check($sformatf("sweep interval[%0h]", v), 32'(cyc), 32'd9);
            check($sformatf("sweep in_ready[%0h]", v), 32'(bad_rdy), 32'd0);
        end
        in_valid = 1'b0;

        // Backpressure: hold result for 20 cycles
        out_ready = 1'b0;
        @(negedge clk);
        x        = 8'hCA;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("bp latency", 32'(cyc), 32'd7);
        stuck_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || y !== 8'h53 || in_ready !== 1'b0) stuck_bad = 1'b1;
        end
        check("bp hold", 32'(stuck_bad), 32'd0);
        check("bp y", 32'(y), 32'h53);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp pop out_valid", 32'(out_valid), 32'd0);
        check("bp pop in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp idle out_valid", 32'(out_valid), 32'd0);

        // Reset three cycles into CALC
        @(negedge clk);
        x        = 8'h53;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-rst y held", 32'(y), 32'h53);
        rst = 1'b1;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst y", 32'(y), 32'h00);
        check("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_one("after rst x8D", 8'h8D, 8'h8D, 8'h02);

        // Operand change after acceptance is ignored
        run_one("x change", 8'h53, 8'hFF, 8'hCA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
